// File: rtl/trigger_detector_pkg.sv
// Shared constants for the trigger detector: FSM state codes and edge-select codes.
package trigger_detector_pkg;

  localparam logic [2:0] TRIG_ST_IDLE = 3'd0;
  localparam logic [2:0] TRIG_ST_PRE  = 3'd1;
  localparam logic [2:0] TRIG_ST_WAIT = 3'd2;
  localparam logic [2:0] TRIG_ST_POST = 3'd3;
  localparam logic [2:0] TRIG_ST_DONE = 3'd4;

  localparam logic TRIG_EDGE_RISING  = 1'b0;
  localparam logic TRIG_EDGE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_detector_comparator.sv
// Combinational hysteresis comparator: reports when a sample leaves the band (arm)
// and when it crosses the threshold in the selected direction (fire).
module trigger_comparator
  import trigger_detector_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [DATA_WIDTH-1:0] level_i,
  input  logic [DATA_WIDTH-1:0] hyst_i,
  input  logic                  edge_i,
  output logic                  arm_cond_o,
  output logic                  fire_cond_o
);

  logic [DATA_WIDTH:0]   lo_ext, hi_ext;
  logic [DATA_WIDTH-1:0] lo, hi;

  // One extra bit catches underflow/overflow so the band edges clamp instead of wrapping.
  assign lo_ext = {1'b0, level_i} - {1'b0, hyst_i};
  assign hi_ext = {1'b0, level_i} + {1'b0, hyst_i};
  assign lo     = lo_ext[DATA_WIDTH] ? '0 : lo_ext[DATA_WIDTH-1:0];
  assign hi     = hi_ext[DATA_WIDTH] ? '1 : hi_ext[DATA_WIDTH-1:0];

  always_comb begin
    if (edge_i == TRIG_EDGE_FALLING) begin
      arm_cond_o  = (sample_i >= hi);
      fire_cond_o = (sample_i <= level_i);
    end else begin
      arm_cond_o  = (sample_i <= lo);
      fire_cond_o = (sample_i >= level_i);
    end
  end

endmodule

// File: rtl/trigger_detector.sv
// Register slice + acquisition FSM (pre-fill, hysteresis trigger search, post count, done).
// Optional auto-trigger after a WAIT timeout is built when TRIG_AUTO_EN is defined.
module trigger_detector
  import trigger_detector_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  SI_data,
  input  logic                   SI_rdy,
  output logic                   SI_ack,
  output logic [DATA_WIDTH-1:0]  SO_data,
  output logic                   SO_trig,
  output logic                   SO_rdy,
  input  logic                   SO_ack,
  input  logic [DATA_WIDTH-1:0]  trig_level,
  input  logic [DATA_WIDTH-1:0]  trig_hyst,
  input  logic                   trig_edge,
  input  logic [COUNT_WIDTH-1:0] pretrig_len,
  input  logic [COUNT_WIDTH-1:0] posttrig_len,
  input  logic [COUNT_WIDTH-1:0] auto_timeout,
  input  logic                   arm,
  input  logic                   force_trig,
  output logic                   triggered,
  output logic                   done
);

  logic [2:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                   below_q, below_d, above_q, above_d;
  logic                   trig_q, trig_d;
  logic [DATA_WIDTH-1:0]  so_data_q;
  logic                   so_trig_q, so_rdy_q;
  logic                   accept, fire, auto_fire;
  logic                   arm_cond, fire_cond, flag;

  assign SI_ack    = !so_rdy_q || SO_ack;
  assign accept    = SI_rdy && SI_ack;
  assign SO_data   = so_data_q;
  assign SO_trig   = so_trig_q;
  assign SO_rdy    = so_rdy_q;
  assign triggered = trig_q;
  assign done      = (state_q == TRIG_ST_DONE);

  trigger_comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .sample_i    (SI_data),
    .level_i     (trig_level),
    .hyst_i      (trig_hyst),
    .edge_i      (trig_edge),
    .arm_cond_o  (arm_cond),
    .fire_cond_o (fire_cond)
  );

  assign flag    = (trig_edge == TRIG_EDGE_FALLING) ? above_q : below_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

`ifdef TRIG_AUTO_EN
  // The shared counter tracks WAIT samples; once it reaches the timeout the next sample fires.
  assign auto_fire = (auto_timeout != '0) && (cnt_q == auto_timeout);
`else
  logic unused_auto;
  assign unused_auto = ^auto_timeout;
  assign auto_fire   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    below_d = below_q;
    above_d = above_q;
    trig_d  = trig_q;
    fire    = 1'b0;
    if (arm) begin
      trig_d  = 1'b0;
      below_d = 1'b0;
      above_d = 1'b0;
      cnt_d   = '0;
      state_d = TRIG_ST_PRE;
      // A sample accepted alongside arm is the first pre-trigger sample.
      if (pretrig_len == '0 || (accept && pretrig_len == COUNT_WIDTH'(1)))
        state_d = TRIG_ST_WAIT;
      else if (accept)
        cnt_d = COUNT_WIDTH'(1);
    end else begin
      case (state_q)
        TRIG_ST_PRE: begin
          if (cnt_q == pretrig_len || (accept && cnt_inc == pretrig_len)) begin
            state_d = TRIG_ST_WAIT;
            cnt_d   = '0;
            below_d = 1'b0;
            above_d = 1'b0;
          end else if (accept) begin
            cnt_d = cnt_inc;
          end
        end
        TRIG_ST_WAIT: begin
          if (accept) begin
            fire = force_trig || auto_fire || (flag && fire_cond);
            if (fire) begin
              trig_d  = 1'b1;
              cnt_d   = '0;
              state_d = (posttrig_len == '0) ? TRIG_ST_DONE : TRIG_ST_POST;
            end else begin
              if (arm_cond && trig_edge == TRIG_EDGE_RISING)  below_d = 1'b1;
              if (arm_cond && trig_edge == TRIG_EDGE_FALLING) above_d = 1'b1;
`ifdef TRIG_AUTO_EN
              cnt_d = cnt_inc;
`endif
            end
          end
        end
        TRIG_ST_POST: begin
          if (accept) begin
            if (cnt_inc == posttrig_len) begin
              state_d = TRIG_ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TRIG_ST_IDLE;
      cnt_q     <= '0;
      below_q   <= 1'b0;
      above_q   <= 1'b0;
      trig_q    <= 1'b0;
      so_data_q <= '0;
      so_trig_q <= 1'b0;
      so_rdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      below_q <= below_d;
      above_q <= above_d;
      trig_q  <= trig_d;
      if (accept) begin
        so_data_q <= SI_data;
        so_trig_q <= fire;
        so_rdy_q  <= 1'b1;
      end else if (SO_ack) begin
        so_rdy_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trigger_detector.sv
// Directed bench for trigger_detector: scoreboard of accepted samples vs drained output.
module tb_trigger_detector;

  logic        clk, rst_n;
  logic [7:0]  SI_data, SO_data, trig_level, trig_hyst;
  logic        SI_rdy, SI_ack, SO_trig, SO_rdy, SO_ack, trig_edge;
  logic [15:0] pretrig_len, posttrig_len, auto_timeout;
  logic        arm, force_trig, triggered, done;

  int          tests, fails, cyc;
  logic        exp_trig_in;
  logic [8:0]  sb[$];

  trigger_detector #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .SI_data(SI_data), .SI_rdy(SI_rdy), .SI_ack(SI_ack),
    .SO_data(SO_data), .SO_trig(SO_trig), .SO_rdy(SO_rdy), .SO_ack(SO_ack),
    .trig_level(trig_level), .trig_hyst(trig_hyst), .trig_edge(trig_edge),
    .pretrig_len(pretrig_len), .posttrig_len(posttrig_len), .auto_timeout(auto_timeout),
    .arm(arm), .force_trig(force_trig), .triggered(triggered), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs only change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (SO_rdy && SO_ack) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("so_data", 32'(SO_data), 32'(e[7:0]));
          chk("so_trig", 32'(SO_trig), 32'(e[8]));
        end
      end
      if (SI_rdy && SI_ack) sb.push_back({exp_trig_in, SI_data});
    end
  end

  task automatic send(input logic [7:0] d, input logic t);
    int n;
    n = 0;
    SI_data = d; exp_trig_in = t; SI_rdy = 1'b1;
    @(negedge clk);
    while (!SI_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_arm();
    SI_rdy = 1'b0;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] lvl, input logic [7:0] hy, input logic e,
                     input logic [15:0] pre, input logic [15:0] post);
    trig_level = lvl; trig_hyst = hy; trig_edge = e;
    pretrig_len = pre; posttrig_len = post;
  endtask

  initial begin
    int c0;
    tests = 0; fails = 0; cyc = 0;
    rst_n = 1'b0; SI_data = '0; SI_rdy = 1'b0; SO_ack = 1'b1; exp_trig_in = 1'b0;
    arm = 1'b0; force_trig = 1'b0; auto_timeout = '0;
    cfg(8'd128, 8'd10, 1'b0, 16'd4, 16'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_si_ack", 32'(SI_ack), 32'd1);
    chk("rst_so_rdy", 32'(SO_rdy), 32'd0);
    chk("rst_so_data", 32'(SO_data), 32'd0);
    chk("rst_so_trig", 32'(SO_trig), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back stream in IDLE, 1-cycle latency, no bubbles
    c0 = cyc;
    send(8'd0, 1'b0);
    chk("lat_so_rdy", 32'(SO_rdy), 32'd1);
    chk("lat_so_data", 32'(SO_data), 32'd0);
    for (int i = 1; i < 10; i++) send(8'(i), 1'b0);
    chk("no_bubbles", 32'(cyc - c0), 32'd10);

    // 2: backpressure for 5 cycles
    for (int i = 10; i < 15; i++) send(8'(i), 1'b0);
    SO_ack = 1'b0; SI_data = 8'd15; SI_rdy = 1'b1; exp_trig_in = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_si_ack", 32'(SI_ack), 32'd0);
      chk("bp_so_data", 32'(SO_data), 32'd14);
    end
    SO_ack = 1'b1;
    for (int i = 15; i < 20; i++) send(8'(i), 1'b0);

    // 3: ramp, rising edge, pre 4, post 8
    cfg(8'd128, 8'd10, 1'b0, 16'd4, 16'd8);
    pulse_arm();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), (i == 128));
      if (i == 127) chk("ramp_trig_before", 32'(triggered), 32'd0);
      if (i == 128) chk("ramp_trig_after", 32'(triggered), 32'd1);
      if (i == 135) chk("ramp_done_early", 32'(done), 32'd0);
      if (i == 136) chk("ramp_done", 32'(done), 32'd1);
    end
    chk("ramp_done_hold", 32'(done), 32'd1);

    // 4: hysteresis, lo = 118; 119 does not arm, 118 does
    cfg(8'd128, 8'd10, 1'b0, 16'd0, 16'd2);
    pulse_arm();
    chk("arm_clears_done", 32'(done), 32'd0);
    send(8'd130, 1'b0); send(8'd125, 1'b0); send(8'd119, 1'b0); send(8'd130, 1'b0);
    chk("hyst_no_trig", 32'(triggered), 32'd0);
    send(8'd118, 1'b0); send(8'd140, 1'b1);
    chk("hyst_trig", 32'(triggered), 32'd1);
    send(8'd1, 1'b0);
    chk("post2_not_done", 32'(done), 32'd0);
    send(8'd2, 1'b0);
    chk("post2_done", 32'(done), 32'd1);

    // 5: falling edge, hi clamps to 255, post 0
    cfg(8'd250, 8'd10, 1'b1, 16'd0, 16'd0);
    pulse_arm();
    send(8'd240, 1'b0); send(8'd254, 1'b0); send(8'd250, 1'b0);
    chk("fall_no_trig", 32'(triggered), 32'd0);
    send(8'd255, 1'b0); send(8'd250, 1'b1);
    chk("fall_trig", 32'(triggered), 32'd1);
    chk("fall_post0_done", 32'(done), 32'd1);

    // 6: force trigger, arm in POST, arm coincident with accept
    cfg(8'd128, 8'd10, 1'b0, 16'd2, 16'd3);
    pulse_arm();
    for (int i = 0; i < 5; i++) send(8'd50, 1'b0);
    force_trig = 1'b1;
    send(8'd50, 1'b1);
    force_trig = 1'b0;
    chk("force_trig", 32'(triggered), 32'd1);
    send(8'd50, 1'b0);
    pulse_arm();
    chk("rearm_triggered", 32'(triggered), 32'd0);
    chk("rearm_done", 32'(done), 32'd0);
    arm = 1'b1;
    send(8'd50, 1'b0);
    arm = 1'b0;
    send(8'd51, 1'b0);
    force_trig = 1'b1;
    send(8'd60, 1'b1);
    force_trig = 1'b0;
    for (int i = 0; i < 3; i++) send(8'd61, 1'b0);
    chk("arm_accept_done", 32'(done), 32'd1);

`ifdef TRIG_AUTO_EN
    cfg(8'd128, 8'd10, 1'b0, 16'd0, 16'd0);
    auto_timeout = 16'd20;
    pulse_arm();
    for (int i = 0; i < 20; i++) send(8'd50, 1'b0);
    chk("auto_not_yet", 32'(triggered), 32'd0);
    send(8'd50, 1'b1);
    chk("auto_trig", 32'(triggered), 32'd1);
    auto_timeout = '0;
`endif

    SI_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
